// File: rtl/opb_register_bank_ppc2simulink.sv
// ---------------------------------------------------------------------------
// opb_register_bank_ppc2simulink
//   OPB slave that exposes C_NUM_REGS 32-bit software-writable registers to
//   user logic. Each hit is acknowledged exactly once, in the ACK state. The
//   FSM then parks in WAIT until the master drops OPB_select. Offsets past
//   the last register get an error acknowledge instead.
//
// Ports
//   OPB_Clk, OPB_Rst_n      clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW    OPB request (IBM bit order, bit 0 = MSB)
//   OPB_select, OPB_seqAddr transfer request; seqAddr is ignored
//   Sl_DBus, Sl_xferAck,    read data and acknowledges, all registered
//   Sl_errAck
//   Sl_retry, Sl_toutSup    tied low
//   user_data_out           register i at bits [32i+31:32i]
//   user_wr_stb             one-cycle strobe per register on every write
// ---------------------------------------------------------------------------
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01030000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010300FF,
    parameter int unsigned C_NUM_REGS   = 4,
    parameter logic [15:0] C_PULSE_MASK = 16'h0000,
    parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:31]               OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_wr_stb
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    state_t                         state_q;
    logic                           xack_q, eack_q;
    logic [31:0]                    rdata_q;
    logic [C_NUM_REGS-1:0]          stb_q, stb_d;
    logic [C_NUM_REGS-1:0][31:0]    regs_q;

    // Bus vectors are declared [0:N]; plain assignment to [N:0] keeps the
    // numeric value, so OPB_DBus[k] lands on bit 31-k and OPB_BE[0] on be[3].
    logic [31:0] addr, wdata, bmask, rd_word;
    logic [3:0]  be, idx;
    logic        in_range, idx_ok, hit, wr_hit, rd_hit;

    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;
    assign be    = OPB_BE;
    assign idx   = OPB_ABus[26:29];

    assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign idx_ok   = {28'd0, idx} < C_NUM_REGS;
    assign hit      = OPB_select && in_range && (state_q == IDLE);
    assign wr_hit   = hit && idx_ok && !OPB_RNW;
    assign rd_hit   = hit && idx_ok && OPB_RNW;

    assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    // Read mux and write decode written as loops so the 4-bit offset never
    // indexes an array that may be smaller than 16 entries.
    always_comb begin
        rd_word = '0;
        stb_d   = '0;
        for (int i = 0; i < int'(C_NUM_REGS); i++) begin
            if (idx == 4'(i)) begin
                rd_word  = regs_q[i];
                stb_d[i] = wr_hit;
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= IDLE;
            xack_q  <= 1'b0;
            eack_q  <= 1'b0;
            rdata_q <= '0;
            stb_q   <= '0;
        end else begin
            xack_q  <= 1'b0;
            eack_q  <= 1'b0;
            rdata_q <= '0;
            stb_q   <= '0;
            case (state_q)
                IDLE: if (hit) begin
                    state_q <= ACK;
                    xack_q  <= idx_ok;
                    eack_q  <= !idx_ok;
                    stb_q   <= stb_d;
                    if (rd_hit) rdata_q <= rd_word;
                end
                ACK:  state_q <= WAIT;
                WAIT: if (!OPB_select) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pulse-mode registers reload the idle value on any edge that is not a
    // write to them, so a written value survives only the ACK cycle.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < int'(C_NUM_REGS); i++) regs_q[i] <= C_RESET_VAL;
        end else begin
            for (int i = 0; i < int'(C_NUM_REGS); i++) begin
                if (stb_d[i])
                    regs_q[i] <= (regs_q[i] & ~bmask) | (wdata & bmask);
                else if (C_PULSE_MASK[i])
                    regs_q[i] <= C_RESET_VAL;
            end
        end
    end

    logic unused_seq;
    assign unused_seq = OPB_seqAddr;

    assign Sl_DBus       = rdata_q;
    assign Sl_xferAck    = xack_q;
    assign Sl_errAck     = eack_q;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_data_out = regs_q;
    assign user_wr_stb   = stb_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// ---------------------------------------------------------------------------
// tb_opb_register_bank_ppc2simulink
//   Directed OPB scenarios followed by random transfers. Expected values come
//   from a register-array model updated with byte-mask arithmetic. Inputs are
//   driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE  = 32'h01030000;
    localparam logic [31:0] HIGH  = 32'h010300FF;
    localparam int          NREG  = 4;
    localparam logic [15:0] PMASK = 16'h0002;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [0:31]   abus = '0, dbus = '0;
    logic [0:3]    be = '0;
    logic          rnw = 1'b0, sel = 1'b0, seq = 1'b0;
    logic [0:31]   sl_dbus;
    logic          xack, eack, retry, tsup;
    logic [127:0]  udo;
    logic [3:0]    stb;

    int checks = 0, failures = 0;
    logic [31:0] m [NREG];

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(NREG),
        .C_PULSE_MASK(PMASK), .C_RESET_VAL(32'h0)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(xack), .Sl_errAck(eack),
        .Sl_retry(retry), .Sl_toutSup(tsup),
        .user_data_out(udo), .user_wr_stb(stb)
    );

    function automatic logic [127:0] mvec();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One in-range transfer: drive, check the ACK cycle, drop select, check WAIT.
    task automatic xfer(input string tag, input logic [31:0] a, input logic r,
                        input logic [3:0] b, input logic [31:0] d);
        int          ix;
        bit          ok;
        logic [31:0] mask, exp_rd;
        logic [3:0]  exp_stb;
        ix = int'((a >> 2) & 32'hF);
        ok = ix < NREG;
        mask = 32'h0;
        for (int j = 0; j < 4; j++) if (b[j]) mask |= 32'hFF << (8 * j);
        exp_rd  = (ok && r) ? m[ix] : 32'h0;
        exp_stb = 4'h0;
        if (ok && !r) begin
            m[ix] = (m[ix] & ~mask) | (d & mask);
            exp_stb = 4'(1 << ix);
        end
        abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({tag, ".xack"}, 128'(xack), 128'(ok));
        chk({tag, ".eack"}, 128'(eack), 128'(!ok));
        chk({tag, ".stb"},  128'(stb),  128'(exp_stb));
        chk({tag, ".rd"},   128'(sl_dbus), 128'(exp_rd));
        chk({tag, ".regs"}, udo, mvec());
        sel = 1'b0;
        for (int i = 0; i < NREG; i++) if (PMASK[i]) m[i] = 32'h0;
        @(posedge clk); @(negedge clk);
        chk({tag, ".wait_ack"}, 128'({xack, eack}), 128'(0));
        chk({tag, ".wait_stb"}, 128'(stb), 128'(0));
        chk({tag, ".wait_rd"},  128'(sl_dbus), 128'(0));
        chk({tag, ".wait_regs"}, udo, mvec());
        @(posedge clk); @(negedge clk);
    endtask

    // Select outside the address window must be ignored entirely.
    task automatic nohit(input string tag, input logic [31:0] a);
        abus = a; rnw = 1'b0; be = 4'hF; dbus = $urandom; sel = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, ".ack"},  128'({xack, eack}), 128'(0));
            chk({tag, ".stb"},  128'(stb), 128'(0));
            chk({tag, ".regs"}, udo, mvec());
        end
        sel = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int acks;
        for (int i = 0; i < NREG; i++) m[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.regs", udo, 128'(0));
        chk("rst.ack",  128'({xack, eack}), 128'(0));
        chk("rst.rd",   128'(sl_dbus), 128'(0));
        chk("rst.stb",  128'(stb), 128'(0));
        chk("rst.tied", 128'({retry, tsup}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        xfer("wr_full",  BASE + 32'h08, 1'b0, 4'b1111, 32'hDEADBEEF);
        xfer("wr_be",    BASE + 32'h00, 1'b0, 4'b0101, 32'h11223344);
        xfer("wr_pulse", BASE + 32'h04, 1'b0, 4'b1111, 32'h000000A5);
        xfer("rd_err",   BASE + 32'h10, 1'b1, 4'b1111, 32'h0);
        xfer("wr_be0",   BASE + 32'h0C, 1'b0, 4'b0000, 32'hFFFFFFFF);
        xfer("rd_reg2",  BASE + 32'h08, 1'b1, 4'b0000, 32'h0);
        xfer("rd_alias", BASE + 32'h40, 1'b1, 4'b1111, 32'h0);
        nohit("nohit_lo", BASE - 32'h4);
        nohit("nohit_hi", HIGH + 32'h1);

        // Select held for 10 cycles yields a single acknowledge
        abus = BASE; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            acks += int'(xack) + int'(eack);
        end
        chk("hold.acks", 128'(acks), 128'(1));
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during ACK aborts the transfer
        abus = BASE + 32'h0C; rnw = 1'b0; be = 4'hF; dbus = 32'h12345678; sel = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rstack.pre", 128'(xack), 128'(1));
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) m[i] = 32'h0;
        chk("rstack.xack", 128'(xack), 128'(0));
        chk("rstack.regs", udo, mvec());
        chk("rstack.stb",  128'(stb), 128'(0));
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer("post_rst_rd", BASE + 32'h0C, 1'b1, 4'hF, 32'h0);
        xfer("post_rst_wr", BASE + 32'h00, 1'b0, 4'hF, 32'hCAFEF00D);

        // Random transfers against the model
        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 7)
                nohit("rnd_nohit", (n % 16 == 7) ? BASE - 32'(1 + $urandom_range(0, 255))
                                                 : HIGH + 32'(1 + $urandom_range(0, 255)));
            else
                xfer("rnd", BASE + 32'($urandom_range(0, 255)), 1'($urandom),
                     4'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
